// File: rtl/status_ctrl.sv
// Flag-writer arbiter for a 4-bit {C,V,N,Z} status register.
// Also holds a LIFO shadow stack for nested exceptions and evaluates the condition field.
module status_ctrl #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    sr_in,
  input  logic          alu_s,
  input  logic [3:0]    alu_flags,
  input  logic          msr_we,
  input  logic [3:0]    msr_flags,
  input  logic [3:0]    msr_mask,
  input  logic          exc_enter,
  input  logic          exc_ret,
  input  logic [3:0]    cond,
  output logic          cond_pass,
  output logic          sr_s,
  output logic [3:0]    sr_flags,
  output logic          alu_drop,
  output logic [PW-1:0] depth,
  output logic [1:0]    stk_err
);

  localparam int            IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);

  logic [3:0]    r_stack [DEPTH];
  logic          r_sr_s;
  logic [3:0]    r_sr_flags;
  logic          r_alu_drop;
  logic [PW-1:0] r_depth;
  logic [1:0]    r_stk_err;

  logic          w_empty;
  logic          w_full;
  logic          w_do_push;
  logic          w_higher;
  logic [IW-1:0] w_top_idx;
  logic [IW-1:0] w_push_idx;
  logic          w_c, w_v, w_n, w_z;

  assign w_empty    = (r_depth == '0);
  assign w_full     = (r_depth == FULL);
  assign w_top_idx  = IW'(r_depth - PW'(1));
  assign w_push_idx = IW'(r_depth);
  assign w_do_push  = exc_enter & ~exc_ret & ~w_full;
  assign w_higher   = exc_ret | exc_enter | msr_we;

  // Stack contents need no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push)
      r_stack[w_push_idx] <= sr_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr_s     <= 1'b0;
      r_sr_flags <= 4'b0000;
      r_alu_drop <= 1'b0;
      r_depth    <= '0;
      r_stk_err  <= 2'b00;
    end else begin
      r_alu_drop <= alu_s & w_higher;
      if (exc_ret) begin
        if (!w_empty) begin
          r_sr_flags <= r_stack[w_top_idx];
          r_sr_s     <= 1'b1;
          r_depth    <= r_depth - PW'(1);
        end else begin
          r_sr_s       <= 1'b0;
          r_stk_err[0] <= 1'b1;
        end
      end else if (exc_enter) begin
        r_sr_s <= 1'b0;
        if (!w_full)
          r_depth <= r_depth + PW'(1);
        else
          r_stk_err[1] <= 1'b1;
      end else if (msr_we) begin
        r_sr_flags <= (sr_in & ~msr_mask) | (msr_flags & msr_mask);
        r_sr_s     <= 1'b1;
      end else if (alu_s) begin
        r_sr_flags <= alu_flags;
        r_sr_s     <= 1'b1;
      end else begin
        r_sr_s <= 1'b0;
      end
    end
  end

  assign sr_s     = r_sr_s;
  assign sr_flags = r_sr_flags;
  assign alu_drop = r_alu_drop;
  assign depth    = r_depth;
  assign stk_err  = r_stk_err;

  assign {w_c, w_v, w_n, w_z} = sr_in;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'd0:    cond_pass = w_z;
      4'd1:    cond_pass = ~w_z;
      4'd2:    cond_pass = w_c;
      4'd3:    cond_pass = ~w_c;
      4'd4:    cond_pass = w_n;
      4'd5:    cond_pass = ~w_n;
      4'd6:    cond_pass = w_v;
      4'd7:    cond_pass = ~w_v;
      4'd8:    cond_pass = w_c & ~w_z;
      4'd9:    cond_pass = ~w_c | w_z;
      4'd10:   cond_pass = (w_n == w_v);
      4'd11:   cond_pass = (w_n != w_v);
      4'd12:   cond_pass = ~w_z & (w_n == w_v);
      4'd13:   cond_pass = w_z | (w_n != w_v);
      4'd14:   cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_status_ctrl.sv
// Bench for status_ctrl: directed scenarios plus random traffic against a queue-based model.
// The bench plays the status register, loading sr_in on the falling edge from the model.
module tb_status_ctrl;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    sr_in = 4'h0;
  logic          alu_s = 1'b0;
  logic [3:0]    alu_flags = 4'h0;
  logic          msr_we = 1'b0;
  logic [3:0]    msr_flags = 4'h0;
  logic [3:0]    msr_mask = 4'h0;
  logic          exc_enter = 1'b0;
  logic          exc_ret = 1'b0;
  logic [3:0]    cond = 4'h0;
  logic          cond_pass;
  logic          sr_s;
  logic [3:0]    sr_flags;
  logic          alu_drop;
  logic [PW-1:0] depth;
  logic [1:0]    stk_err;

  status_ctrl #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk(clk), .reset(reset), .sr_in(sr_in), .alu_s(alu_s), .alu_flags(alu_flags),
    .msr_we(msr_we), .msr_flags(msr_flags), .msr_mask(msr_mask),
    .exc_enter(exc_enter), .exc_ret(exc_ret), .cond(cond), .cond_pass(cond_pass),
    .sr_s(sr_s), .sr_flags(sr_flags), .alu_drop(alu_drop), .depth(depth), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [3:0] m_stack[$];
  logic       m_s = 1'b0;
  logic [3:0] m_flags = 4'h0;
  logic       m_drop = 1'b0;
  logic [1:0] m_err = 2'b00;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Condition codes come in true/false pairs: evaluate the even member, invert for odd.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic cc, vv, nn, zz, base;
    {cc, vv, nn, zz} = f;
    case (c[3:1])
      3'd0: base = zz;
      3'd1: base = cc;
      3'd2: base = nn;
      3'd3: base = vv;
      3'd4: base = cc && !zz;
      3'd5: base = (nn == vv);
      3'd6: base = !zz && (nn == vv);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic model_reset();
    m_stack.delete();
    m_s = 1'b0; m_flags = 4'h0; m_drop = 1'b0; m_err = 2'b00;
  endtask

  task automatic idle_inputs();
    alu_s = 0; msr_we = 0; exc_enter = 0; exc_ret = 0;
  endtask

  // One clock: predict from current inputs, check after the edge, then update sr_in.
  task automatic step(input string tag);
    m_drop = alu_s && (exc_ret || exc_enter || msr_we);
    if (exc_ret) begin
      if (m_stack.size() > 0) begin m_flags = m_stack.pop_back(); m_s = 1'b1; end
      else begin m_s = 1'b0; m_err[0] = 1'b1; end
    end else if (exc_enter) begin
      m_s = 1'b0;
      if (m_stack.size() < DEPTH) m_stack.push_back(sr_in);
      else m_err[1] = 1'b1;
    end else if (msr_we) begin
      m_flags = (sr_in & ~msr_mask) | (msr_flags & msr_mask);
      m_s = 1'b1;
    end else if (alu_s) begin
      m_flags = alu_flags; m_s = 1'b1;
    end else begin
      m_s = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, ".sr_s"},     8'(sr_s),     8'(m_s));
    chk({tag, ".sr_flags"}, 8'(sr_flags), 8'(m_flags));
    chk({tag, ".alu_drop"}, 8'(alu_drop), 8'(m_drop));
    chk({tag, ".depth"},    8'(depth),    8'(m_stack.size()));
    chk({tag, ".stk_err"},  8'(stk_err),  8'(m_err));
    $display("%s: s=%0b flags=%b drop=%0b depth=%0d err=%b", tag, sr_s, sr_flags, alu_drop, depth, stk_err);
    idle_inputs();
    @(negedge clk);
    if (m_s) sr_in = m_flags;
    #1;
    chk({tag, ".cond_pass"}, 8'(cond_pass), 8'(ref_cond(cond, sr_in)));
  endtask

  initial begin
    idle_inputs();
    #12;
    chk("rst.sr_s", 8'(sr_s), 8'h0);
    chk("rst.depth", 8'(depth), 8'h0);
    chk("rst.stk_err", 8'(stk_err), 8'h0);
    @(negedge clk); reset = 1'b1; model_reset();

    // 1: plain ALU update, then idle
    alu_s = 1; alu_flags = 4'b1001; step("t1_alu");
    chk("t1.flags", 8'(sr_flags), 8'h9);
    step("t1_idle");

    // 2: masked MSR beats ALU
    sr_in = 4'b1111; msr_we = 1; msr_flags = 4'b0000; msr_mask = 4'b0101;
    alu_s = 1; alu_flags = 4'b0011; step("t2_msr");
    chk("t2.flags", 8'(sr_flags), 8'hA);
    chk("t2.drop", 8'(alu_drop), 8'h1);
    step("t2_idle");

    // 3: nested entry and LIFO return
    sr_in = 4'b0001; exc_enter = 1; step("t3_enter0");
    sr_in = 4'b0110; exc_enter = 1; step("t3_enter1");
    chk("t3.depth2", 8'(depth), 8'h2);
    exc_ret = 1; step("t3_ret0");
    chk("t3.first", 8'(sr_flags), 8'h6);
    exc_ret = 1; exc_enter = 1; step("t3_ret1");
    chk("t3.second", 8'(sr_flags), 8'h1);
    chk("t3.noerr", 8'(stk_err), 8'h0);

    // 4: overflow then underflow
    for (int i = 0; i < 5; i++) begin
      sr_in = 4'(i + 3); exc_enter = 1; step($sformatf("t4_enter%0d", i));
    end
    chk("t4.full", 8'(depth), 8'h4);
    chk("t4.ovf", 8'(stk_err), 8'h2);
    for (int i = 0; i < 5; i++) begin
      exc_ret = 1; step($sformatf("t4_ret%0d", i));
    end
    chk("t4.err", 8'(stk_err), 8'h3);
    chk("t4.s", 8'(sr_s), 8'h0);

    // 5: condition table sweep
    for (int f = 0; f < 16; f++)
      for (int c = 0; c < 16; c++) begin
        sr_in = 4'(f); cond = 4'(c); #1;
        chk($sformatf("t5_cond%0d_f%0d", c, f), 8'(cond_pass), 8'(ref_cond(4'(c), 4'(f))));
      end
    sr_in = 4'b0011;
    cond = 4'd12; #1; chk("t5.GT", 8'(cond_pass), 8'h0);
    cond = 4'd13; #1; chk("t5.LE", 8'(cond_pass), 8'h1);
    cond = 4'd0;  #1; chk("t5.EQ", 8'(cond_pass), 8'h1);
    m_s = 1'b0;
    @(negedge clk);
    step("t5_resync");

    // 6: async reset with depth 2 and strobe active
    reset = 1'b0; #2; @(negedge clk); reset = 1'b1; model_reset();
    exc_enter = 1; step("t6_enter0");
    exc_enter = 1; step("t6_enter1");
    alu_s = 1; alu_flags = 4'b0101; step("t6_alu");
    chk("t6.pre_s", 8'(sr_s), 8'h1);
    #1 reset = 1'b0; #1;
    chk("t6.rst_s", 8'(sr_s), 8'h0);
    chk("t6.rst_flags", 8'(sr_flags), 8'h0);
    chk("t6.rst_drop", 8'(alu_drop), 8'h0);
    chk("t6.rst_depth", 8'(depth), 8'h0);
    chk("t6.rst_err", 8'(stk_err), 8'h0);
    model_reset();
    @(negedge clk); reset = 1'b1;
    exc_ret = 1; step("t6_ret");
    chk("t6.udf", 8'(stk_err), 8'h1);

    // Random traffic
    reset = 1'b0; #2; @(negedge clk); reset = 1'b1; model_reset();
    for (int i = 0; i < 400; i++) begin
      exc_ret   = ($urandom_range(0, 5) == 0);
      exc_enter = ($urandom_range(0, 4) == 0);
      msr_we    = ($urandom_range(0, 3) == 0);
      alu_s     = ($urandom_range(0, 1) == 0);
      alu_flags = 4'($urandom);
      msr_flags = 4'($urandom);
      msr_mask  = 4'($urandom);
      cond      = 4'($urandom);
      if ($urandom_range(0, 7) == 0) sr_in = 4'($urandom);
      step($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
